regfile_sb: RTL
===============

# regfile_sb

Parametrised register file with an integrated pending-write scoreboard for the pipelined RISC-V core. It is the successor to the plain two-read/one-write register file and generalises width and depth. It adds synchronous reset, optional hardwired-zero register, same-cycle write-to-read bypass and per-register busy tracking for long-latency writebacks. Decode reads operands and busy flags here, issue allocates destinations, and writeback retires them.

## Interface
Parameters:
- XLEN, 64, data width in bits
- NREGS, 32, number of architectural registers (power of two, ≥ 2)
- ZERO_REG, 1, when 1 register 0 reads as zero, ignores writes and is never busy

Ports (AW = $clog2(NREGS), CW = $clog2(NREGS+1)):
- clk  in  1  rising-edge clock, single clock domain
- rst  in  1  synchronous reset, active-high
- address1  in  AW  read port 1 address
- address2  in  AW  read port 2 address
- read1  out  XLEN  read port 1 data
- read2  out  XLEN  read port 2 data
- busy1  out  1  register at address1 has a pending write
- busy2  out  1  register at address2 has a pending write
- alloc_valid  in  1  issue requests to reserve a destination
- alloc_addr  in  AW  destination to reserve
- alloc_ready  out  1  reservation accepted this cycle
- writeEn  in  1  writeback valid
- addressw  in  AW  writeback address
- writeData  in  XLEN  writeback data
- busy_count  out  CW  number of registers currently busy
- wb_stray  out  1  sticky: a writeback hit a non-busy register

## Operation
- Read: readN = array[addressN]. If writeEn && addressw == addressN, return writeData (bypass) and report busyN = 0. If ZERO_REG && addressN == 0, return 0 and busyN = 0.
- Write: on writeEn, array[addressw] <= writeData at the edge. It is ignored for register 0 when ZERO_REG=1.
- Writeback clears busy[addressw]. If busy[addressw] was 0 (excluding ZERO_REG reg 0), data is still written and wb_stray is set (sticky until rst).
- alloc_ready = !busy[alloc_addr] || (writeEn && addressw == alloc_addr). A busy destination stalls (WAW protection).
- Accepted alloc (alloc_valid && alloc_ready) sets busy[alloc_addr] at the edge. With ZERO_REG and alloc_addr == 0, it is always ready and sets nothing.
- Simultaneous writeback and accepted alloc on the same register: data is written and busy stays 1; busy_count is unchanged.
- busy_count is the registered population count. It increments on an accepted alloc that sets a bit and decrements on a writeback that clears a bit. Both events on different registers leave it unchanged.

## Timing
- Reads and busyN are combinational (zero latency) from addresses and writeback inputs.
- alloc_ready is combinational from registered busy state and the writeback inputs. It must not depend on alloc_valid.
- Writes, busy updates, busy_count and wb_stray take effect at the next rising clk edge.
- Reset: all registers 0, busy all 0, busy_count 0, wb_stray 0. Reads during reset reflect the array and bypass normally. Reset dominates alloc and writeback in the same cycle; nothing is committed.
- Reset mid-operation discards all pending reservations.

## Structure
- Package regfile_pkg: default XLEN/NREGS constants and a function computing AW/CW from NREGS.
- Sub-module regfile_busy_tracker: holds the busy vector, alloc_ready, busy_count and wb_stray. The top holds the data array, read muxes and bypass.
- Data array is a flop array with synchronous reset. No RAM macro is used, because of the reset requirement.

## Test plan
- Reset, then read address1=5/address2=0 → read1=0, read2=0, busy1=busy2=0, busy_count=0.
- Writeback writeEn=1, addressw=7, writeData=64'hDEAD_BEEF with address1=7 in the same cycle → read1=DEAD_BEEF combinationally. The next cycle still reads DEAD_BEEF and wb_stray=1.
- Alloc reg 3, then alloc reg 3 again → second alloc_ready=0 and busy1=1 at address1=3. Writeback reg 3 with alloc reg 3 in the same cycle → alloc_ready=1 and busy_count stays 1.
- ZERO_REG=1: writeback addressw=0 data=1 → read1 at address 0 is 0. Alloc addr 0 → ready=1 and busy_count stays 0.
- Allocate all 31 nonzero registers → busy_count=31. Assert rst with writeEn=1 → next cycle busy_count=0, all reads 0, and wb_stray=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and width helpers for the register file and its scoreboard.
// Latency: none (compile-time only).
// Backpressure: not applicable.
package regfile_pkg;

  localparam int XLEN_DEFAULT  = 64;
  localparam int NREGS_DEFAULT = 32;

  // Width of a register index.
  function automatic int addr_width(input int nregs);
    return $clog2(nregs);
  endfunction

  // Width able to hold a count from 0 up to and including nregs.
  function automatic int count_width(input int nregs);
    return $clog2(nregs + 1);
  endfunction

endpackage

// File: rtl/regfile_busy_tracker.sv
// Pending-write scoreboard: one busy bit per register, set by issue and cleared by writeback.
// Latency: alloc_ready is combinational; busy bits, busy_count and wb_stray update at the next edge.
// Backpressure: alloc_ready drops while the destination is busy, unless this cycle's writeback frees it.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   alloc_valid/alloc_addr    reservation request from issue
//   alloc_ready               reservation accepted this cycle
//   wb_en/wb_addr             writeback retiring a destination
//   busy_vec                  registered busy bit per register
//   busy_count                registered population count of busy_vec
//   wb_stray                  sticky flag: a writeback hit a register that was not busy
module regfile_busy_tracker
  import regfile_pkg::*;
#(
  parameter int NREGS    = NREGS_DEFAULT,
  parameter bit ZERO_REG = 1'b1,
  localparam int AW      = addr_width(NREGS),
  localparam int CW      = count_width(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_valid,
  input  logic [AW-1:0]    alloc_addr,
  output logic             alloc_ready,
  input  logic             wb_en,
  input  logic [AW-1:0]    wb_addr,
  output logic [NREGS-1:0] busy_vec,
  output logic [CW-1:0]    busy_count,
  output logic             wb_stray
);

  logic zero_alloc;
  logic zero_wb;
  logic wb_hits_alloc;
  logic alloc_set;
  logic wb_clr;
  logic cnt_inc;
  logic cnt_dec;

  assign zero_alloc    = ZERO_REG && (alloc_addr == '0);
  assign zero_wb       = ZERO_REG && (wb_addr == '0);
  assign wb_hits_alloc = wb_en && (wb_addr == alloc_addr);

  // A writeback to the requested destination frees it in the same cycle, so
  // the new reservation can be taken without a bubble.
  assign alloc_ready = zero_alloc || !busy_vec[alloc_addr] || wb_hits_alloc;

  assign alloc_set = alloc_valid && alloc_ready && !zero_alloc;
  assign wb_clr    = wb_en && !zero_wb;

  // Count moves only on real 0->1 / 1->0 transitions. When alloc and writeback
  // target the same busy register, the bit stays set and the count stays put.
  assign cnt_inc = alloc_set && !busy_vec[alloc_addr];
  assign cnt_dec = wb_clr && busy_vec[wb_addr] && !(alloc_set && (alloc_addr == wb_addr));

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_vec   <= '0;
      busy_count <= '0;
      wb_stray   <= 1'b0;
    end else begin
      // Alloc is applied after the clear so it wins on a shared address.
      if (wb_clr)    busy_vec[wb_addr]    <= 1'b0;
      if (alloc_set) busy_vec[alloc_addr] <= 1'b1;
      busy_count <= busy_count + CW'(cnt_inc) - CW'(cnt_dec);
      if (wb_clr && !busy_vec[wb_addr]) wb_stray <= 1'b1;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Two-read/one-write register file with write-to-read bypass and a pending-write scoreboard.
// Latency: reads and busy flags are combinational; writes and scoreboard updates land at the next edge.
// Backpressure: alloc_ready stalls issue while its destination still has a pending write.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   address1/address2 -> read1/read2 operand reads (bypassed from writeback)
//   busy1/busy2                      operand register has a pending write
//   alloc_valid/alloc_addr/alloc_ready  destination reservation from issue
//   writeEn/addressw/writeData       writeback port
//   busy_count                       number of busy registers
//   wb_stray                         sticky: writeback to a non-busy register seen
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int NREGS    = NREGS_DEFAULT,
  parameter bit ZERO_REG = 1'b1,
  localparam int AW      = addr_width(NREGS),
  localparam int CW      = count_width(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   address1,
  input  logic [AW-1:0]   address2,
  output logic [XLEN-1:0] read1,
  output logic [XLEN-1:0] read2,
  output logic            busy1,
  output logic            busy2,
  input  logic            alloc_valid,
  input  logic [AW-1:0]   alloc_addr,
  output logic            alloc_ready,
  input  logic            writeEn,
  input  logic [AW-1:0]   addressw,
  input  logic [XLEN-1:0] writeData,
  output logic [CW-1:0]   busy_count,
  output logic            wb_stray
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy_vec;
  logic             wr_ok;

  regfile_busy_tracker #(
    .NREGS    (NREGS),
    .ZERO_REG (ZERO_REG)
  ) u_busy (
    .clk         (clk),
    .rst         (rst),
    .alloc_valid (alloc_valid),
    .alloc_addr  (alloc_addr),
    .alloc_ready (alloc_ready),
    .wb_en       (writeEn),
    .wb_addr     (addressw),
    .busy_vec    (busy_vec),
    .busy_count  (busy_count),
    .wb_stray    (wb_stray)
  );

  assign wr_ok = writeEn && !(ZERO_REG && (addressw == '0));

  // Flop array rather than a RAM so every entry can be cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[addressw] <= writeData;
    end
  end

  // Priority: hardwired zero over bypass over array. A bypassed operand is
  // being produced this cycle, so it is no longer reported busy.
  always_comb begin
    read1 = regs[address1];
    busy1 = busy_vec[address1];
    if (writeEn && (addressw == address1)) begin
      read1 = writeData;
      busy1 = 1'b0;
    end
    if (ZERO_REG && (address1 == '0)) begin
      read1 = '0;
      busy1 = 1'b0;
    end
  end

  always_comb begin
    read2 = regs[address2];
    busy2 = busy_vec[address2];
    if (writeEn && (addressw == address2)) begin
      read2 = writeData;
      busy2 = 1'b0;
    end
    if (ZERO_REG && (address2 == '0)) begin
      read2 = '0;
      busy2 = 1'b0;
    end
  end

endmodule
